// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Multi-cycle iterative restoring divider for the execute stage.
//               Accepts a dividend/divisor pair over a valid/ready handshake,
//               retires one quotient bit per clock and presents a registered
//               quotient, remainder and divide-by-zero flag over a second
//               valid/ready handshake. One operation in flight at a time.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WORD_SIZE   operand, quotient and remainder width in bits
//   CNT_W       iteration counter width (2**CNT_W > WORD_SIZE)
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   in_valid     in   dividend/divisor valid
//   in_ready     out  divider idle and able to accept an operation
//   dividend     in   numerator, sampled on in_valid & in_ready
//   divisor      in   denominator, sampled on in_valid & in_ready
//   out_valid    out  result valid
//   out_ready    in   consumer accepts result
//   quotient     out  result quotient
//   remainder    out  result remainder
//   div_by_zero  out  divisor was zero for this result
//   busy         out  operation in progress or result pending
// Configuration
//   SEQ_DIVIDER_SIGNED_EN  when defined, operands are two's complement and
//                          the result truncates toward zero; otherwise all
//                          operands and results are unsigned.
// ============================================================================
module seq_divider #(
    parameter int WORD_SIZE = 19,
    parameter int CNT_W     = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_SIZE-1:0] dividend,
    input  logic [WORD_SIZE-1:0] divisor,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] quotient,
    output logic [WORD_SIZE-1:0] remainder,
    output logic                 div_by_zero,
    output logic                 busy
);

    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_CALC = 2'd1;
    localparam logic [1:0] C_DONE = 2'd2;

    localparam logic [CNT_W-1:0] C_LAST_STEP = CNT_W'(WORD_SIZE - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]           state_q,       state_d;
    logic [CNT_W-1:0]     cnt_q,         cnt_d;
    // dvd_q shifts the dividend out at the top while quotient bits enter at
    // the bottom; after the last step it holds the quotient.
    logic [WORD_SIZE-1:0] dvd_q,         dvd_d;
    logic [WORD_SIZE-1:0] dsr_q,         dsr_d;
    // Partial remainder carries one extra bit so the shifted value never
    // overflows before the compare/subtract.
    logic [WORD_SIZE:0]   rem_q,         rem_d;
    logic                 dbz_q,         dbz_d;
    logic [WORD_SIZE-1:0] quotient_q,    quotient_d;
    logic [WORD_SIZE-1:0] remainder_q,   remainder_d;
    logic                 div_by_zero_q, div_by_zero_d;
    logic                 out_valid_q,   out_valid_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
    logic                 q_neg_q,       q_neg_d;
    logic                 r_neg_q,       r_neg_d;
`endif

    // ------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------
    logic [WORD_SIZE:0]   rem_shift;
    logic                 rem_ge;
    logic [WORD_SIZE:0]   rem_sub;
    logic [WORD_SIZE:0]   rem_step;
    logic [WORD_SIZE-1:0] quo_step;
    logic [WORD_SIZE-1:0] dvd_mag;
    logic [WORD_SIZE-1:0] dsr_mag;
    // Top bit of the stored partial remainder is always zero after a step
    // (remainder < divisor), so it is never read back.
    logic                 unused_rem_msb;

    assign unused_rem_msb = rem_q[WORD_SIZE];

    assign rem_shift = {rem_q[WORD_SIZE-1:0], dvd_q[WORD_SIZE-1]};
    assign rem_ge    = (rem_shift >= {1'b0, dsr_q});
    assign rem_sub   = rem_shift - {1'b0, dsr_q};
    assign rem_step  = rem_ge ? rem_sub : rem_shift;
    assign quo_step  = {dvd_q[WORD_SIZE-2:0], rem_ge};

`ifdef SEQ_DIVIDER_SIGNED_EN
    // The most-negative value has magnitude 2**(WORD_SIZE-1), which still
    // fits in WORD_SIZE unsigned bits, so no extra width is needed.
    assign dvd_mag = dividend[WORD_SIZE-1] ? ('0 - dividend) : dividend;
    assign dsr_mag = divisor[WORD_SIZE-1]  ? ('0 - divisor)  : divisor;
`else
    assign dvd_mag = dividend;
    assign dsr_mag = divisor;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        dvd_d         = dvd_q;
        dsr_d         = dsr_q;
        rem_d         = rem_q;
        dbz_d         = dbz_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;
        out_valid_d   = out_valid_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
        q_neg_d       = q_neg_q;
        r_neg_d       = r_neg_q;
`endif

        case (state_q)
            C_IDLE: begin
                if (in_valid) begin
                    cnt_d = '0;
                    if (divisor == '0) begin
                        // Result is known immediately; skip the iteration.
                        dvd_d   = '1;
                        rem_d   = {1'b0, dividend};
                        dsr_d   = '0;
                        dbz_d   = 1'b1;
                        state_d = C_DONE;
                    end else begin
                        dvd_d   = dvd_mag;
                        dsr_d   = dsr_mag;
                        rem_d   = '0;
                        dbz_d   = 1'b0;
                        state_d = C_CALC;
`ifdef SEQ_DIVIDER_SIGNED_EN
                        q_neg_d = dividend[WORD_SIZE-1] ^ divisor[WORD_SIZE-1];
                        r_neg_d = dividend[WORD_SIZE-1];
`endif
                    end
                end
            end

            C_CALC: begin
                dvd_d = quo_step;
                rem_d = rem_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == C_LAST_STEP) begin
                    cnt_d   = '0;
                    state_d = C_DONE;
`ifdef SEQ_DIVIDER_SIGNED_EN
                    // Sign correction folded into the final step so the
                    // signed build keeps the same latency.
                    if (q_neg_q) begin
                        dvd_d = '0 - quo_step;
                    end
                    if (r_neg_q) begin
                        rem_d = {1'b0, ({WORD_SIZE{1'b0}} - rem_step[WORD_SIZE-1:0])};
                    end
`endif
                end
            end

            C_DONE: begin
                if (!out_valid_q) begin
                    // First DONE cycle: transfer the result to the output
                    // registers; out_ready has no effect until out_valid.
                    quotient_d    = dvd_q;
                    remainder_d   = rem_q[WORD_SIZE-1:0];
                    div_by_zero_d = dbz_q;
                    out_valid_d   = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = C_IDLE;
                end
            end

            default: begin
                state_d     = C_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= C_IDLE;
            cnt_q         <= '0;
            dvd_q         <= '0;
            dsr_q         <= '0;
            rem_q         <= '0;
            dbz_q         <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
            out_valid_q   <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            q_neg_q       <= 1'b0;
            r_neg_q       <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            dvd_q         <= dvd_d;
            dsr_q         <= dsr_d;
            rem_q         <= rem_d;
            dbz_q         <= dbz_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
            out_valid_q   <= out_valid_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
            q_neg_q       <= q_neg_d;
            r_neg_q       <= r_neg_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready    = (state_q == C_IDLE);
    assign busy        = (state_q != C_IDLE);
    assign out_valid   = out_valid_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;

endmodule
`default_nettype wire
